// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: reads operand A, sign-extends the immediate,
// and buffers the bundle in a 2-entry skid buffer with valid/ready on both sides.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [2:0]        rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [2:0]        out_rt,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_imm
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              push;
  logic              pop;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [DATA_W-1:0] in_imm;

  logic [3:0]        skid_opcode;
  logic [2:0]        skid_rt;
  logic [DATA_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_imm;

  assign rs_addr   = in_instr[11:9];
  assign in_imm    = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flush wins over everything; otherwise the main register always holds the head entry.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_opcode <= '0;
      out_rt     <= '0;
      out_a      <= '0;
      out_imm    <= '0;
    end else if (load_main_in) begin
      out_opcode <= in_instr[15:12];
      out_rt     <= in_instr[8:6];
      out_a      <= rs_data;
      out_imm    <= in_imm;
    end else if (load_main_skid) begin
      out_opcode <= skid_opcode;
      out_rt     <= skid_rt;
      out_a      <= skid_a;
      out_imm    <= skid_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_opcode <= '0;
      skid_rt     <= '0;
      skid_a      <= '0;
      skid_imm    <= '0;
    end else if (load_skid) begin
      skid_opcode <= in_instr[15:12];
      skid_rt     <= in_instr[8:6];
      skid_a      <= rs_data;
      skid_imm    <= in_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a queue-based model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  rs_addr;
  logic [15:0] rs_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rt;
  logic [15:0] out_a;
  logic [15:0] out_imm;

  typedef struct {
    int unsigned instr;
    int unsigned a;
  } entry_t;

  entry_t q[$];
  int tests_run;
  int tests_failed;

  id_ex_operand_stage #(.DATA_W(16), .IMM_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rt     (out_rt),
    .out_a      (out_a),
    .out_imm    (out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned actual, input int unsigned expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] data,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    rs_data   = data;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic int unsigned sext_imm(input int unsigned instr);
    int unsigned imm6;
    imm6 = instr % 64;
    return (imm6 >= 32) ? (imm6 + 32'hFFC0) : imm6;
  endfunction

  // Compare DUT against the queue model: occupancy determines valid/ready, head gives data.
  task automatic checkOutput();
    check("in_ready", in_ready, (q.size() < 2) ? 1 : 0);
    check("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
    check("rs_addr", rs_addr, (in_instr / 512) % 8);
    if (q.size() > 0) begin
      check("out_opcode", out_opcode, q[0].instr / 4096);
      check("out_rt", out_rt, (q[0].instr / 64) % 8);
      check("out_a", out_a, q[0].a);
      check("out_imm", out_imm, sext_imm(q[0].instr));
    end
  endtask

  task automatic updateModel();
    bit can_push;
    bit do_pop;
    can_push = (q.size() < 2);
    do_pop   = out_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (in_valid && can_push) q.push_back('{instr: in_instr, a: rs_data});
    end
  endtask

  task automatic tick();
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_opcode", out_opcode, 0);
    check("reset out_a", out_a, 0);
    check("reset out_imm", out_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push and immediate sign extension
    applyStimulus(1'b1, 16'h5A3F, 16'h0010, 1'b1, 1'b0);
    #1 check("lit rs_addr", rs_addr, 3'h5);
    tick();
    check("lit valid", out_valid, 1);
    check("lit opcode", out_opcode, 4'h5);
    check("lit rt", out_rt, 3'h0);
    check("lit a", out_a, 16'h0010);
    check("lit imm 3F", out_imm, 16'hFFFF);
    applyStimulus(1'b1, 16'h001F, 16'h1234, 1'b1, 1'b0);
    tick();
    check("lit imm 1F", out_imm, 16'h001F);
    applyStimulus(1'b1, 16'h0020, 16'h4321, 1'b1, 1'b0);
    tick();
    check("lit imm 20", out_imm, 16'hFFE0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();

    // Streaming 8 instructions at full rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'((i << 12) | (i << 6) | i), 16'(16'h0100 + i), 1'b1, 1'b0);
      tick();
      check("stream in_ready", in_ready, 1);
      check("stream opcode", out_opcode, i);
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();

    // Backpressure: two absorbed, third stalls until the first pop
    applyStimulus(1'b1, 16'hA000, 16'h000A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hB000, 16'h000B, 1'b0, 1'b0);
    tick();
    check("bp in_ready low", in_ready, 0);
    applyStimulus(1'b1, 16'hC000, 16'h000C, 1'b0, 1'b0);
    tick();
    check("bp head A", out_opcode, 4'hA);
    applyStimulus(1'b1, 16'hC000, 16'h000C, 1'b1, 1'b0);
    tick();
    check("bp head B", out_opcode, 4'hB);
    check("bp in_ready back", in_ready, 1);
    tick();
    check("bp head C", out_opcode, 4'hC);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();
    check("bp drained", out_valid, 0);

    // Flush in state TWO with an offered instruction
    applyStimulus(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h2000, 16'h0002, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h3000, 16'h0003, 1'b1, 1'b1);
    tick();
    check("flush out_valid", out_valid, 0);
    check("flush in_ready", in_ready, 1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();
    check("flush stays empty", out_valid, 0);

    // Asynchronous reset between edges while in state ONE
    applyStimulus(1'b1, 16'h7123, 16'h0777, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("pre-reset valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 0);
    check("async in_ready", in_ready, 1);
    check("async out_opcode", out_opcode, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute pipeline stage of the 16-bit CPU. It accepts one instruction word per cycle from fetch/decode, reads operand A from the register file, and sign-extends the 6-bit immediate to 16 bits. It buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides. Its outputs feed the execute-stage units directly: the immediate comparator (`A < immediate`, unsigned), the ALU and ADDI.

## Interface
Parameters:
- `DATA_W`, default 16: operand width. Only 16 is supported.
- `IMM_W`, default 6: immediate field width in the instruction.

Ports:
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  Upstream presents `in_instr`.
- `in_ready`  out  1  Stage can accept. Registered output.
- `in_instr`  in  16  Instruction word: opcode[15:12], rs[11:9], rt[8:6], imm[5:0].
- `rs_addr`  out  3  Register-file read address. Combinational: `in_instr[11:9]`.
- `rs_data`  in  16  Register-file read data. Combinational read, valid in the same cycle as `in_instr`.
- `flush`  in  1  Discard all buffered entries (branch taken / exception).
- `out_valid`  out  1  Execute-stage bundle valid.
- `out_ready`  in  1  Execute stage consumes the bundle.
- `out_opcode`  out  4  Opcode of the head entry.
- `out_rt`  out  3  Destination register of the head entry.
- `out_a`  out  16  Operand A (`rs_data` captured at accept).
- `out_imm`  out  16  Sign-extended immediate.

## Operation
- push = `in_valid & in_ready`. pop = `out_valid & out_ready`.
- Entry contents: {opcode, rt, a, imm16}.
- `imm16 = {{10{imm[5]}}, imm[5:0]}`. Example: 6'h3F gives 16'hFFFF, 6'h1F gives 16'h001F.
- The downstream comparator treats `out_imm` as unsigned. This stage only performs the sign extension and never reinterprets the value.
- Storage: a main register that drives the outputs, plus one skid register.
- States: EMPTY, ONE, TWO.
  - EMPTY: push → ONE (main ← input).
  - ONE, push & pop → ONE (main ← input).
  - ONE, push & !pop → TWO (skid ← input).
  - ONE, !push & pop → EMPTY.
  - ONE, no push and no pop → hold.
  - TWO: no push possible (`in_ready` = 0). pop → ONE (main ← skid). Otherwise hold.
- `out_valid` = 1 in states ONE and TWO.
- `in_ready` is registered. It is 0 exactly while in state TWO.
- Flush has priority over push and pop. Any state → EMPTY at the next edge. An input offered in the flush cycle is discarded. A pop in the flush cycle still counts as consumed by downstream.
- Data registers are not cleared on pop or flush. Their contents are don't-care while `out_valid` = 0.
- Order is strictly FIFO. No entry is ever dropped except by flush.

## Timing
- Reset (async assert): state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_opcode`/`out_rt`/`out_a`/`out_imm` = 0.
- Reset release: the first push can occur in the first cycle after deassertion.
- Latency: accept at edge N makes `out_valid` = 1 with that entry's data during cycle N+1.
- Throughput: 1 instruction/cycle sustained while `out_ready` = 1.
- Backpressure: the cycle `out_ready` drops, one more push is absorbed into the skid register. `in_ready` goes low the following cycle.
- Recovery from TWO: a pop returns the state to ONE. `in_ready` rises one cycle after that pop.
- `rs_addr` has zero latency from `in_instr`. `rs_data` is sampled at the same edge as the push.
- Reset asserted mid-operation: all entries are lost immediately. Outputs take their reset values asynchronously.

## Test plan
- Reset then single push of `in_instr` 16'h5A3F with `rs_data` 16'h0010 → next cycle: `out_valid` = 1, `out_opcode` = 4'h5, `rs_addr` was 3'h5, `out_rt` = 3'h0, `out_a` = 16'h0010, `out_imm` = 16'hFFFF.
- Imm 6'h1F vs 6'h20 → `out_imm` 16'h001F and 16'hFFE0 respectively.
- Streaming 8 instructions with `out_ready` = 1 → 8 outputs on consecutive cycles, in order, `in_ready` constantly 1.
- `out_ready` = 0 while pushing 3 back-to-back → the first 2 are accepted, `in_ready` = 0 from the 3rd cycle. Raising `out_ready` drains the entries in order. `in_ready` = 1 the cycle after the first pop. The 3rd instruction is then accepted.
- `flush` in state TWO with simultaneous `in_valid` → next cycle: `out_valid` = 0, `in_ready` = 1. The offered instruction never appears at the output.
- Assert `rst_n` = 0 asynchronously between edges while in state ONE → `out_valid` drops to 0 and `in_ready` goes to 1 without waiting for a clock edge.
